muldiv_sequencer: RTL and testbench

Iterative multiply/divide sequencer owning the shared HI/LO arithmetic resource of the multicycle MIPS core. The main control FSM issues a start request with an opcode and two operands. The block then runs a WIDTH-step shift-add multiply or restoring divide and returns HI/LO with a one-cycle write strobe. Divide-by-zero is flagged to the control FSM for exception handling. Sits between the register-file A/B outputs and the HI/LO registers; replaces ad-hoc load/wait states in the control FSM with a start/done handshake.

---
 rtl/muldiv_pkg.sv | 18 +
 rtl/muldiv_if.sv | 33 +++
 rtl/muldiv_step.sv | 51 +++++
 rtl/muldiv_sequencer.sv | 174 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types for the HI/LO multiply/divide sequencer.
// Holds the sequencer state encoding and the op encodings used on the
// start/done interface. Signed operation is selected at build time with
// the MULDIV_SIGNED_EN macro (see muldiv_sequencer.sv).
package muldiv_pkg;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ITER  = 3'd1,
      S_FIX   = 3'd2,
      S_DONE  = 3'd3,
      S_DZERO = 3'd4
   } state_e;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: start/done handshake between the core control FSM (master)
// and the multiply/divide sequencer (slave).
//
// Handshake: the master raises start with op/a/b valid; the sequencer
// accepts it on the first rising edge where it is idle (busy low) and
// samples op/a/b only on that edge. busy then stays high until the end of
// the single-cycle done pulse. done marks completion; hl_we accompanies it
// when hi/lo were updated, div_zero accompanies it instead when the
// divisor was zero (hi/lo untouched). start while busy is ignored.
interface muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic             hl_we;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, a, b,
      input  busy, done, div_zero, hl_we, hi, lo
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, div_zero, hl_we, hi, lo
   );
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the sequencer.
// Multiply: conditional add of |a| into the upper half, then shift right.
// Divide: restoring trial subtract of |b| from {rem, next dividend bit}.
// Registers not used by the selected op pass through unchanged.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               op,
   input  logic [2*WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0]   rem_i,
   input  logic [WIDTH-1:0]   quo_i,
   input  logic [WIDTH-1:0]   mag_a,
   input  logic [WIDTH-1:0]   mag_b,
   output logic [2*WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0]   rem_o,
   output logic [WIDTH-1:0]   quo_o
);

   logic [WIDTH:0]   upper;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] trial;

   // Single shift-add / trial-subtract step selected by op.
   always_comb begin
      acc_o   = acc_i;
      rem_o   = rem_i;
      quo_o   = quo_i;
      // Upper half widened by one bit so the carry of the add survives
      // the right shift.
      upper   = {1'b0, acc_i[2*WIDTH-1:WIDTH]};
      if (acc_i[0]) begin
         upper = upper + {1'b0, mag_a};
      end
      shifted = {rem_i, quo_i[WIDTH-1]};
      // Only consumed when shifted >= |b|, in which case the difference
      // fits in WIDTH bits because rem < |b| on entry.
      trial   = shifted[WIDTH-1:0] - mag_b;
      if (op == OP_MUL) begin
         acc_o = {upper, acc_i[WIDTH-1:1]};
      end else if (shifted >= {1'b0, mag_b}) begin
         rem_o = trial;
         quo_o = {quo_i[WIDTH-2:0], 1'b1};
      end else begin
         rem_o = shifted[WIDTH-1:0];
         quo_o = {quo_i[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative multiply/divide unit owning HI/LO.
// WIDTH iterations of shift-add multiply or restoring divide on operand
// magnitudes, then a FIX cycle applying sign correction and writing HI/LO,
// then a one-cycle DONE. Divide by zero short-circuits to DZERO.
// Build option: define MULDIV_SIGNED_EN for two's-complement operands;
// otherwise operands are unsigned and FIX is a plain copy (same latency).
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic    clk,
   input  logic    reset,
   muldiv_if.slave bus,
   output state_e  dbg_state
);

   localparam int CW = $clog2(WIDTH);

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [WIDTH-1:0]   mag_a_q, mag_a_d;
   logic [WIDTH-1:0]   mag_b_q, mag_b_d;
   logic               sa_q, sa_d;
   logic               sb_q, sb_d;
   logic               op_q, op_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;

   logic               sign_a, sign_b;
   logic [WIDTH-1:0]   in_mag_a, in_mag_b;
   logic [2*WIDTH-1:0] step_acc;
   logic [WIDTH-1:0]   step_rem, step_quo;
   logic [2*WIDTH-1:0] mul_res;
   logic [WIDTH-1:0]   quo_res, rem_res;

`ifdef MULDIV_SIGNED_EN
   assign sign_a = bus.a[WIDTH-1];
   assign sign_b = bus.b[WIDTH-1];
`else
   assign sign_a = 1'b0;
   assign sign_b = 1'b0;
`endif

   // Magnitudes of the live operands; only captured on the accept edge.
   // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude.
   assign in_mag_a = sign_a ? -bus.a : bus.a;
   assign in_mag_b = sign_b ? -bus.b : bus.b;

   // Sign correction for FIX; with signs forced low this is a plain copy.
   // Remainder takes the dividend's sign, quotient the XOR of both.
   assign mul_res = (sa_q ^ sb_q) ? -acc_q : acc_q;
   assign quo_res = (sa_q ^ sb_q) ? -quo_q : quo_q;
   assign rem_res = sa_q ? -rem_q : rem_q;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .op    (op_q),
      .acc_i (acc_q),
      .rem_i (rem_q),
      .quo_i (quo_q),
      .mag_a (mag_a_q),
      .mag_b (mag_b_q),
      .acc_o (step_acc),
      .rem_o (step_rem),
      .quo_o (step_quo)
   );

   // Next-state and datapath register updates for the sequencer FSM.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      mag_a_d = mag_a_q;
      mag_b_d = mag_b_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      op_d    = op_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if ((bus.op == OP_DIV) && (bus.b == '0)) begin
                  // No operand latch: the datapath keeps its old contents.
                  state_d = S_DZERO;
               end else begin
                  op_d    = bus.op;
                  sa_d    = sign_a;
                  sb_d    = sign_b;
                  mag_a_d = in_mag_a;
                  mag_b_d = in_mag_b;
                  cnt_d   = CW'(WIDTH - 1);
                  if (bus.op == OP_MUL) begin
                     acc_d = {{WIDTH{1'b0}}, in_mag_b};
                  end else begin
                     rem_d = '0;
                     quo_d = in_mag_a;
                  end
                  state_d = S_ITER;
               end
            end
         end
         S_ITER: begin
            acc_d = step_acc;
            rem_d = step_rem;
            quo_d = step_quo;
            if (cnt_q == '0) begin
               state_d = S_FIX;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_FIX: begin
            if (op_q == OP_MUL) begin
               hi_d = mul_res[2*WIDTH-1:WIDTH];
               lo_d = mul_res[WIDTH-1:0];
            end else begin
               hi_d = rem_res;
               lo_d = quo_res;
            end
            state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         S_DZERO: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         mag_a_q <= '0;
         mag_b_q <= '0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         op_q    <= OP_MUL;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         mag_a_q <= mag_a_d;
         mag_b_q <= mag_b_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         op_q    <= op_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Status strobes are decoded straight from the registered state.
   assign bus.busy     = (state_q != S_IDLE);
   assign bus.done     = (state_q == S_DONE) || (state_q == S_DZERO);
   assign bus.div_zero = (state_q == S_DZERO);
   assign bus.hl_we    = (state_q == S_DONE);
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
   assign dbg_state    = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and randomized stimulus for muldiv_sequencer
// with a scoreboard fed by an arithmetic reference model.
`timescale 1ns/1ps
module tb_muldiv_sequencer;
   import muldiv_pkg::*;

   localparam int W = 32;

   typedef struct {
      int         cyc;
      logic       dz;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
   } exp_t;

   logic   clk;
   logic   reset;
   state_e dbg_state;
   logic   finish_req;

   muldiv_if #(.WIDTH(W)) bus ();

   muldiv_sequencer #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   exp_t         exp_q[$];
   int           cyc       = 0;
   int           busy_from = 1;
   int           busy_to   = 0;
   logic [W-1:0] cur_hi    = '0;
   logic [W-1:0] cur_lo    = '0;
   int           checks    = 0;
   int           failures  = 0;

   // Reference result from plain arithmetic.
   function automatic exp_t model(input logic op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, input int acc_cyc);
      exp_t           e;
      logic [2*W-1:0] p;
      longint         q;
      longint         r;
      e.dz  = (op == OP_DIV) && (b == '0);
      e.cyc = e.dz ? acc_cyc : acc_cyc + W + 1;
      e.hi  = '0;
      e.lo  = '0;
      p = '0;
      q = 0;
      r = 0;
      if (op == OP_MUL) begin
`ifdef MULDIV_SIGNED_EN
         p = longint'($signed(a)) * longint'($signed(b));
`else
         p = 64'(a) * 64'(b);
`endif
         e.hi = p[2*W-1:W];
         e.lo = p[W-1:0];
      end else if (!e.dz) begin
`ifdef MULDIV_SIGNED_EN
         q = longint'($signed(a)) / longint'($signed(b));
         r = longint'($signed(a)) % longint'($signed(b));
`else
         q = longint'(64'(a) / 64'(b));
         r = longint'(64'(a) % 64'(b));
`endif
         e.lo = q[W-1:0];
         e.hi = r[W-1:0];
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, req);
      end
   endtask

   // ---------------- model + monitor ----------------
   initial begin : monitor
      exp_t e;
      logic armed;
      logic prev_done;
      logic exp_busy, exp_done, exp_dz;
      armed     = 1'b0;
      prev_done = 1'b0;
      forever begin
         @(posedge clk);
         cyc++;
         if (reset) begin
            exp_q.delete();
            cur_hi    = '0;
            cur_lo    = '0;
            busy_from = cyc;
            busy_to   = cyc - 2;
            armed     = 1'b1;
         end else if (bus.start && (cyc >= busy_to + 2)) begin
            e = model(bus.op, bus.a, bus.b, cyc);
            exp_q.push_back(e);
            busy_from = cyc;
            busy_to   = e.cyc;
         end
         @(negedge clk);
         if (armed) begin
            while ((exp_q.size() > 0) && (exp_q[0].cyc < cyc)) begin
               checks++;
               failures++;
               $display("FAIL done_missing cyc=%0d actual=none required=done@%0d", cyc, exp_q[0].cyc);
               void'(exp_q.pop_front());
            end
            exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
            exp_done = (exp_q.size() > 0) && (exp_q[0].cyc == cyc);
            exp_dz   = exp_done && exp_q[0].dz;
            if (exp_done) begin
               e = exp_q.pop_front();
               if (!e.dz) begin
                  cur_hi = e.hi;
                  cur_lo = e.lo;
               end
            end
            chk("busy",     W'(bus.busy),     W'(exp_busy));
            chk("done",     W'(bus.done),     W'(exp_done));
            chk("div_zero", W'(bus.div_zero), W'(exp_dz));
            chk("hl_we",    W'(bus.hl_we),    W'(exp_done && !exp_dz));
            chk("hi",       bus.hi,           cur_hi);
            chk("lo",       bus.lo,           cur_lo);
            chk("done_consec", W'(bus.done && prev_done), '0);
            if (!exp_busy) begin
               chk("idle_state", W'(dbg_state), W'(S_IDLE));
            end
            prev_done = bus.done;
         end
         if (finish_req || (cyc > 20000)) begin
            chk("drain_empty", W'(exp_q.size()), '0);
            if (!finish_req) begin
               checks++;
               failures++;
               $display("FAIL cycle_budget cyc=%0d actual=running required=finished", cyc);
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         if (cyc >= busy_to + 1) break;
         @(negedge clk);
      end
   endtask

   task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      wait_idle();
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = $urandom();
      bus.b     = $urandom();
   endtask

   function automatic logic [W-1:0] rand_opnd();
      logic [W-1:0] v;
      case ($urandom_range(0, 7))
         0:       v = '0;
         1, 2:    v = W'($urandom_range(1, 15));
         3:       v = {1'b1, {(W-1){1'b0}}};
         default: v = $urandom();
      endcase
      return v;
   endfunction

   // ---------------- stimulus ----------------
   initial begin : stim
      reset      = 1'b1;
      finish_req = 1'b0;
      bus.start  = 1'b0;
      bus.op     = OP_MUL;
      bus.a      = '0;
      bus.b      = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      issue(OP_MUL, 32'd7, 32'd6);
`ifdef MULDIV_SIGNED_EN
      issue(OP_MUL, 32'hFFFF_FFFD, 32'd5);
      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
`else
      issue(OP_MUL, 32'hFFFF_FFFF, 32'd2);
`endif
      issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      issue(OP_DIV, 32'd100, 32'd7);
      // Leaves hi=0x1234, lo=0x5678 for the divide-by-zero check.
      issue(OP_DIV, 32'h5678_1234, 32'h0001_0000);
      issue(OP_DIV, 32'h0000_DEAD, 32'd0);
      issue(OP_MUL, 32'd3, 32'd3);

      // Start while busy is ignored; reset mid-flight discards the result.
      issue(OP_MUL, 32'd1000, 32'd1000);
      repeat (3) @(negedge clk);
      bus.start = 1'b1;
      bus.op    = OP_DIV;
      bus.a     = 32'd55;
      bus.b     = 32'd5;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      // Back-to-back with start held high and operands churning.
      issue(OP_MUL, 32'd12, 32'd13);
      wait_idle();
      bus.start = 1'b1;
      for (int i = 0; i < 6 * (W + 3); i++) begin
         bus.op = ($urandom_range(0, 1) == 1) ? OP_DIV : OP_MUL;
         bus.a  = rand_opnd();
         bus.b  = rand_opnd();
         @(negedge clk);
      end
      bus.start = 1'b0;

      // Randomized single operations.
      for (int i = 0; i < 40; i++) begin
         issue(($urandom_range(0, 1) == 1) ? OP_DIV : OP_MUL, rand_opnd(), rand_opnd());
      end

      for (int i = 0; i < 200; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      repeat (2) @(negedge clk);
      finish_req = 1'b1;
   end

endmodule
